// File: rtl/cmp_eqge_serial.sv
// Digit-serial EQ/GE/GT/LT comparator for wide operands.
// Scans MSB-first, DIGIT bits per cycle. With EARLY_EXIT set it stops at the first
// differing digit; otherwise it always scans every digit for constant latency.
// Signed mode inverts the MSB of the top digit on both operands, which turns a
// two's-complement compare into an unsigned one.
module cmp_eqge_serial #(
   parameter int WIDTH      = 64,
   parameter int DIGIT      = 16,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             signed_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             eq_o,
   output logic             ge_o,
   output logic             gt_o,
   output logic             lt_o
);

   localparam int NCHUNK = WIDTH / DIGIT;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0]    TOP_IDX  = IW'(NCHUNK - 1);
   localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

   // Operand width must split into whole digits.
   if ((WIDTH % DIGIT) != 0) begin : g_width_check
      $fatal(1, "cmp_eqge_serial: WIDTH must be a multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             decided_q, decided_d;
   logic             gt_lat_q, gt_lat_d;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic             eq_q, eq_d;
   logic             ge_q, ge_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;

   logic [DIGIT-1:0] a_sel_s, b_sel_s;
   logic [DIGIT-1:0] a_dig_s, b_dig_s;
   logic [DIGIT-1:0] flip_s;
   logic             dgt_s, ddif_s;
   logic             dec_nxt_s, gt_nxt_s, finish_s;

   // Select the current digit of each operand and apply the signed-mode MSB flip.
   always_comb begin
      a_sel_s = '0;
      b_sel_s = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IW'(i)) begin
            a_sel_s = a_q[i*DIGIT +: DIGIT];
            b_sel_s = b_q[i*DIGIT +: DIGIT];
         end else begin
            a_sel_s = a_sel_s;
            b_sel_s = b_sel_s;
         end
      end
      flip_s  = (sgn_q && (idx_q == TOP_IDX)) ? MSB_MASK : '0;
      a_dig_s = a_sel_s ^ flip_s;
      b_dig_s = b_sel_s ^ flip_s;
      dgt_s   = a_dig_s > b_dig_s;
      ddif_s  = a_dig_s != b_dig_s;
   end

   // Next-state, operand capture and result formation.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      gt_lat_d  = gt_lat_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      eq_d      = eq_q;
      ge_d      = ge_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      dec_nxt_s = decided_q | ddif_s;
      gt_nxt_s  = decided_q ? gt_lat_q : dgt_s;
      finish_s  = ((EARLY_EXIT != 0) && ddif_s) || (idx_q == '0);
      if (flush_i) begin
         // Abort wins over accept and over the output handshake.
         state_d = ST_IDLE;
         ready_d = 1'b1;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  a_d       = a_i;
                  b_d       = b_i;
                  sgn_d     = signed_i;
                  idx_d     = TOP_IDX;
                  decided_d = 1'b0;
                  gt_lat_d  = 1'b0;
                  ready_d   = 1'b0;
                  state_d   = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               decided_d = dec_nxt_s;
               gt_lat_d  = gt_nxt_s;
               if (finish_s) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
                  eq_d    = ~dec_nxt_s;
                  gt_d    = dec_nxt_s & gt_nxt_s;
                  lt_d    = dec_nxt_s & ~gt_nxt_s;
                  ge_d    = ~dec_nxt_s | gt_nxt_s;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
            ST_DONE: begin
               if (ready_i) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sgn_q     <= 1'b0;
         idx_q     <= '0;
         decided_q <= 1'b0;
         gt_lat_q  <= 1'b0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         eq_q      <= 1'b0;
         ge_q      <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sgn_q     <= sgn_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         gt_lat_q  <= gt_lat_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         eq_q      <= eq_d;
         ge_q      <= ge_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign eq_o    = eq_q;
   assign ge_o    = ge_q;
   assign gt_o    = gt_q;
   assign lt_o    = lt_q;

endmodule

// File: tb/tb_cmp_eqge_serial.sv
// Self-checking bench for cmp_eqge_serial: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_cmp_eqge_serial;

   localparam int W  = 64;
   localparam int D  = 16;
   localparam int NC = W / D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_ni   = 1'b0;
   logic         valid_i  = 1'b0;
   logic         ready_o;
   logic [W-1:0] a_i      = '0;
   logic [W-1:0] b_i      = '0;
   logic         signed_i = 1'b0;
   logic         flush_i  = 1'b0;
   logic         valid_o;
   logic         ready_i  = 1'b1;
   logic         eq_o, ge_o, gt_o, lt_o;

   logic         valid_z  = 1'b0;
   logic         ready_zo;
   logic [W-1:0] a_z      = '0;
   logic [W-1:0] b_z      = '0;
   logic         signed_z = 1'b0;
   logic         valid_zo;
   logic         eq_z, ge_z, gt_z, lt_z;

   cmp_eqge_serial #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .eq_o(eq_o), .ge_o(ge_o), .gt_o(gt_o), .lt_o(lt_o));

   cmp_eqge_serial #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) dut_z (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_z), .ready_o(ready_zo),
      .a_i(a_z), .b_i(b_z), .signed_i(signed_z), .flush_i(1'b0),
      .valid_o(valid_zo), .ready_i(1'b1),
      .eq_o(eq_z), .ge_o(ge_z), .gt_o(gt_z), .lt_o(lt_z));

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference result as {eq, ge, gt, lt} straight from integer comparison.
   function automatic logic [3:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic eq, gt;
      eq = (a == b);
      gt = s ? ($signed(a) > $signed(b)) : (a > b);
      return {eq, eq | gt, gt, ~eq & ~gt};
   endfunction

   // Number of scan cycles: stops at the highest differing digit when early exit is on.
   function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b, input int ee);
      if (ee == 0) return NC;
      for (int i = NC - 1; i >= 0; i--) begin
         if (((a >> (i * D)) & 64'hFFFF) != ((b >> (i * D)) & 64'hFFFF)) return NC - i;
      end
      return NC;
   endfunction

   // Transaction-level model of the early-exit instance.
   bit       m_busy  = 1'b0;
   bit       m_valid = 1'b0;
   int       m_cnt   = 0;
   logic [3:0] m_pend  = 4'h0;
   logic [3:0] m_flags = 4'h0;

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_cnt   <= 0;
      end else if (flush_i) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
            m_flags <= m_pend;
         end
      end else if (m_valid) begin
         if (ready_i) m_valid <= 1'b0;
      end else if (valid_i) begin
         m_busy <= 1'b1;
         m_cnt  <= ref_k(a_i, b_i, 1);
         m_pend <= ref_flags(a_i, b_i, signed_i);
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_ni) begin
         chk(ready_o == !(m_busy || m_valid), "ready_o", 64'(ready_o), 64'(!(m_busy || m_valid)));
         chk(valid_o == m_valid, "valid_o", 64'(valid_o), 64'(m_valid));
         if (m_valid && valid_o)
            chk({eq_o, ge_o, gt_o, lt_o} == m_flags, "flags", 64'({eq_o, ge_o, gt_o, lt_o}), 64'(m_flags));
      end
   end

   task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int stall, input int exp_k, input logic [3:0] exp_f, input string name);
      int n;
      logic [3:0] f;
      @(posedge clk); #1;
      a_i = a; b_i = b; signed_i = s; valid_i = 1'b1; ready_i = (stall == 0);
      @(posedge clk); #1;
      valid_i = 1'b0; a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; signed_i = ~s;
      n = 0;
      while (!valid_o && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (stall > 0) valid_i = 1'($urandom % 2);
      end
      chk(n == exp_k, {name, " latency"}, 64'(n), 64'(exp_k));
      f = {eq_o, ge_o, gt_o, lt_o};
      chk(f == exp_f, {name, " flags"}, 64'(f), 64'(exp_f));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         valid_i = 1'($urandom % 2);
         chk(valid_o && ({eq_o, ge_o, gt_o, lt_o} == f), {name, " stall hold"},
             64'({valid_o, eq_o, ge_o, gt_o, lt_o}), 64'({1'b1, f}));
      end
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk); #1;
      chk(ready_o && !valid_o, {name, " ready after handshake"}, 64'({ready_o, valid_o}), 64'(2'b10));
   endtask

   task automatic run_z(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [3:0] exp_f, input string name);
      int n;
      @(posedge clk); #1;
      a_z = a; b_z = b; signed_z = s; valid_z = 1'b1;
      @(posedge clk); #1;
      valid_z = 1'b0; a_z = ~a; b_z = '0;
      n = 0;
      while (!valid_zo && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk(n == 4, {name, " latency"}, 64'(n), 64'd4);
      chk({eq_z, ge_z, gt_z, lt_z} == exp_f, {name, " flags"}, 64'({eq_z, ge_z, gt_z, lt_z}), 64'(exp_f));
      @(posedge clk); #1;
      chk(ready_zo && !valid_zo, {name, " ready after handshake"}, 64'({ready_zo, valid_zo}), 64'(2'b10));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int j;
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk(ready_o && !valid_o && ({eq_o, ge_o, gt_o, lt_o} == 4'h0), "reset state",
          64'({ready_o, valid_o, eq_o, ge_o, gt_o, lt_o}), 64'(6'b100000));
      rst_ni = 1'b1;

      // Pin the reference model to hand-computed values.
      chk(ref_flags(64'h8000_0000_0000_0000, 64'h1, 1'b0) == 4'b0110, "model unsigned gt",
          64'(ref_flags(64'h8000_0000_0000_0000, 64'h1, 1'b0)), 64'(4'b0110));
      chk(ref_flags(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1) == 4'b0001, "model signed lt",
          64'(ref_flags(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1)), 64'(4'b0001));
      chk(ref_k(64'h8000_0000_0000_0000, 64'h1, 1) == 1, "model k top digit",
          64'(ref_k(64'h8000_0000_0000_0000, 64'h1, 1)), 64'd1);
      chk(ref_k(64'h1234_0000_0000_0001, 64'h1234_0000_0000_0002, 1) == 4, "model k low digit",
          64'(ref_k(64'h1234_0000_0000_0001, 64'h1234_0000_0000_0002, 1)), 64'd4);

      // Directed cases
      run_req(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, 1, 4'b0110, "unsigned top gt");
      run_req(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 4, 4'b1100, "equal");
      run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 1, 4'b0001, "signed -1 vs 0");
      run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 0, 1, 4'b0110, "unsigned max vs 0");
      run_req(64'h1234_0000_0000_0001, 64'h1234_0000_0000_0002, 1'b0, 3, 4, 4'b0001, "stalled lt");

      // Flush in the second RUN cycle
      @(posedge clk); #1;
      a_i = 64'hDEAD_BEEF_0123_4567; b_i = 64'hDEAD_BEEF_0123_4567; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk(ready_o && !valid_o, "flush to idle", 64'({ready_o, valid_o}), 64'(2'b10));
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk(!valid_o, "no result after flush", 64'(valid_o), 64'd0);
      end
      run_req(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0, 0, 3, 4'b0110, "after flush");

      // Asynchronous reset mid-RUN
      @(posedge clk); #1;
      a_i = 64'h8000_0000_0000_0000; b_i = 64'h8000_0000_0000_0000; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b0;
      #1;
      chk(ready_o && !valid_o && ({eq_o, ge_o, gt_o, lt_o} == 4'h0), "async reset immediate",
          64'({ready_o, valid_o, eq_o, ge_o, gt_o, lt_o}), 64'(6'b100000));
      @(posedge clk); #1;
      chk(ready_o && !valid_o && ({eq_o, ge_o, gt_o, lt_o} == 4'h0), "async reset next cycle",
          64'({ready_o, valid_o, eq_o, ge_o, gt_o, lt_o}), 64'(6'b100000));
      rst_ni = 1'b1;

      // Constant-latency instance
      run_z(64'h8000_0000_0000_0000, 64'h1, 1'b0, 4'b0110, "no-early-exit gt");
      run_z(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'b0001, "no-early-exit signed lt");
      run_z(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 4'b1100, "no-early-exit eq");

      // Randomized traffic with stalls, flushes and operands changing while busy
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         valid_i  = ($urandom_range(0, 2) != 0);
         signed_i = 1'($urandom % 2);
         a_i      = {$urandom, $urandom};
         case ($urandom % 5)
            0: b_i = a_i;
            1: b_i = {$urandom, $urandom};
            2: b_i = a_i ^ 64'h8000_0000_0000_0000;
            default: begin
               j = int'($urandom % 4);
               b_i = a_i;
               b_i[j*D +: D] = b_i[j*D +: D] ^ 16'($urandom_range(1, 65535));
            end
         endcase
         ready_i = ($urandom % 4 != 0);
         flush_i = ($urandom % 50 == 0);
      end
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
